// File: rtl/roachf_seed_pkg.sv
// Shared types and constants for the ROACH F-engine LFSR seed loader.
package roachf_seed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } seed_state_e;

    localparam int unsigned CTRL_ARM = 0;
    localparam int unsigned CTRL_IMM = 1;
    localparam int unsigned CTRL_CLR = 2;

    localparam int unsigned STATUS_BUSY      = 0;
    localparam int unsigned STATUS_ARMED     = 1;
    localparam int unsigned STATUS_OVERRUN   = 2;
    localparam int unsigned STATUS_LANES_LSB = 8;
    localparam int unsigned STATUS_LANES_W   = 8;
    localparam int unsigned STATUS_SEQ_LSB   = 16;
    localparam int unsigned STATUS_SEQ_W     = 16;

    localparam logic [31:0] DEFAULT_SEED_STRIDE = 32'h9E3779B9;

    // Software-visible status word, MSB first.
    typedef struct packed {
        logic [STATUS_SEQ_W-1:0]   seq_count;
        logic [STATUS_LANES_W-1:0] lanes_loaded;
        logic [4:0]                rsvd;
        logic                      overrun;
        logic                      armed;
        logic                      busy;
    } seed_status_t;

    // An all-zero seed would lock an LFSR, so substitute 1.
    function automatic logic [31:0] nonzero_seed(input logic [31:0] seed);
        return (seed == 32'h0) ? 32'h0000_0001 : seed;
    endfunction

endpackage

// File: rtl/roachf_rise_det.sv
// Single-bit rising-edge detector with async active-low reset.
module roachf_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise_c
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise_c = i_d & ~r_q;

endmodule

// File: rtl/roachf_seed_load_ctrl.sv
// Loads software-armed derived seeds into N_LANES F-engine noise LFSRs,
// one lane per valid/ready handshake, optionally gated by the F-engine sync.
module roachf_seed_load_ctrl
    import roachf_seed_pkg::*;
#(
    parameter int unsigned N_LANES     = 8,
    parameter logic [31:0] SEED_STRIDE = DEFAULT_SEED_STRIDE
) (
    input  logic                       user_clk,
    input  logic                       user_rst_n,
    input  logic [31:0]                seed_data,
    input  logic [31:0]                ctrl_reg,
    input  logic                       sync_in,
    output logic [$clog2(N_LANES)-1:0] lane_sel,
    output logic [31:0]                lane_seed,
    output logic                       lane_valid,
    input  logic                       lane_ready,
    output logic                       done_pulse,
    output logic [31:0]                status_reg
);

    localparam int unsigned SEL_W = $clog2(N_LANES);
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_LANES - 1);

    seed_state_e r_state;
    seed_state_e w_state_nxt;

    logic [31:0]      r_acc;
    logic [SEL_W-1:0] r_lane_sel;
    logic [31:0]      r_lane_seed;
    logic             r_lane_valid;
    logic             r_done_pulse;
    logic [7:0]       r_lanes_loaded;
    logic [15:0]      r_seq_count;
    logic             r_overrun;
    logic             r_busy;
    logic             r_armed;

    logic [31:0]      w_acc_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [7:0]       w_lanes_nxt;
    logic             w_ovr_nxt;
    logic             w_done_nxt;
    logic             w_arm_rise;
    logic             w_clr_rise;
    logic             w_accept;
    logic             w_last;
    seed_status_t     w_status;
    logic             w_unused_ctrl;

    assign w_unused_ctrl = &{1'b0, ctrl_reg[31:3]};

    roachf_rise_det u_arm_det (
        .clk      (user_clk),
        .rst_n    (user_rst_n),
        .i_d      (ctrl_reg[CTRL_ARM]),
        .o_rise_c (w_arm_rise)
    );

    roachf_rise_det u_clr_det (
        .clk      (user_clk),
        .rst_n    (user_rst_n),
        .i_d      (ctrl_reg[CTRL_CLR]),
        .o_rise_c (w_clr_rise)
    );

    assign w_accept = (r_state == LOAD) & r_lane_valid & lane_ready;
    assign w_last   = w_accept & (r_lane_sel == LAST_LANE);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_arm_rise) begin
                    w_state_nxt = ctrl_reg[CTRL_IMM] ? LOAD : ARMED;
                end
            end
            ARMED: begin
                if (sync_in) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for the registered datapath and outputs.
    always_comb begin
        w_acc_nxt   = r_acc;
        w_sel_nxt   = r_lane_sel;
        w_lanes_nxt = r_lanes_loaded;
        w_ovr_nxt   = r_overrun;
        w_done_nxt  = 1'b0;
        if ((r_state == IDLE) && w_arm_rise) begin
            w_acc_nxt   = seed_data;
            w_sel_nxt   = '0;
            w_lanes_nxt = '0;
        end
        if (w_accept) begin
            w_acc_nxt   = r_acc + SEED_STRIDE;
            w_lanes_nxt = r_lanes_loaded + 8'd1;
            w_sel_nxt   = w_last ? '0 : r_lane_sel + SEL_W'(1);
        end
        if (w_last) begin
            w_done_nxt = 1'b1;
        end
        if (w_clr_rise) begin
            w_ovr_nxt = 1'b0;
        end
        // A set in the same cycle as a clear wins.
        if (w_arm_rise && (r_state != IDLE)) begin
            w_ovr_nxt = 1'b1;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_acc          <= '0;
            r_lane_sel     <= '0;
            r_lane_seed    <= '0;
            r_lane_valid   <= 1'b0;
            r_done_pulse   <= 1'b0;
            r_lanes_loaded <= '0;
            r_overrun      <= 1'b0;
            r_busy         <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            r_acc          <= w_acc_nxt;
            r_lane_sel     <= w_sel_nxt;
            r_lane_seed    <= nonzero_seed(w_acc_nxt);
            r_lane_valid   <= (w_state_nxt == LOAD);
            r_done_pulse   <= w_done_nxt;
            r_lanes_loaded <= w_lanes_nxt;
            r_overrun      <= w_ovr_nxt;
            r_busy         <= (w_state_nxt != IDLE);
            r_armed        <= (w_state_nxt == ARMED);
        end
    end

    // Completed-sequence counter, wraps naturally at 16 bits.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_seq_count <= '0;
        end else if (w_last) begin
            r_seq_count <= r_seq_count + 16'd1;
        end
    end

    always_comb begin
        w_status              = '0;
        w_status.seq_count    = r_seq_count;
        w_status.lanes_loaded = r_lanes_loaded;
        w_status.overrun      = r_overrun;
        w_status.armed        = r_armed;
        w_status.busy         = r_busy;
    end

    assign lane_sel   = r_lane_sel;
    assign lane_seed  = r_lane_seed;
    assign lane_valid = r_lane_valid;
    assign done_pulse = r_done_pulse;
    assign status_reg = w_status;

endmodule

// File: tb/tb_roachf_seed_load_ctrl.sv
// Directed self-checking bench for roachf_seed_load_ctrl.
module tb_roachf_seed_load_ctrl;

    localparam int unsigned N      = 8;
    localparam logic [31:0] STRIDE = 32'h9E3779B9;

    logic        user_clk = 1'b0;
    logic        user_rst_n;
    logic [31:0] seed_data;
    logic [31:0] ctrl_reg;
    logic        sync_in;
    logic [2:0]  lane_sel;
    logic [31:0] lane_seed;
    logic        lane_valid;
    logic        lane_ready;
    logic        done_pulse;
    logic [31:0] status_reg;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_seq;

    roachf_seed_load_ctrl #(
        .N_LANES     (N),
        .SEED_STRIDE (STRIDE)
    ) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .seed_data  (seed_data),
        .ctrl_reg   (ctrl_reg),
        .sync_in    (sync_in),
        .lane_sel   (lane_sel),
        .lane_seed  (lane_seed),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .done_pulse (done_pulse),
        .status_reg (status_reg)
    );

    always #5 user_clk = ~user_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge user_clk);
        #1;
    endtask

    // Lane k gets base + k*STRIDE, with an all-zero result replaced by 1.
    function automatic logic [31:0] exp_seed(input logic [31:0] base, input int k);
        logic [31:0] s;
        s = base + 32'(k) * STRIDE;
        return (s == 32'h0) ? 32'h0000_0001 : s;
    endfunction

    // Entered on the first lane_valid cycle; walks all lanes, then checks DONE.
    task automatic run_lanes(input string tag, input logic [31:0] base, input bit bp,
                             input logic [31:0] rearm_ctrl, input bit chg_seed);
        int k   = 0;
        int cyc = 0;
        while (k < int'(N) && cyc < 64) begin
            chk({tag, "_valid"}, 32'(lane_valid), 32'd1);
            chk({tag, "_sel"},   32'(lane_sel),   32'(k));
            chk({tag, "_seed"},  lane_seed,       exp_seed(base, k));
            chk({tag, "_nodone"}, 32'(done_pulse), 32'd0);
            lane_ready = bp ? (cyc % 2 == 0) : 1'b1;
            if (rearm_ctrl != 32'h0 && cyc == 1) ctrl_reg = 32'h0;
            if (rearm_ctrl != 32'h0 && cyc == 2) ctrl_reg = rearm_ctrl;
            if (chg_seed && cyc == 3) seed_data = ~seed_data;
            if (lane_ready) k++;
            cyc++;
            tick();
        end
        if (k < int'(N)) chk({tag, "_timeout"}, 32'(k), 32'(N));
        exp_seq = exp_seq + 16'd1;
        chk({tag, "_done"},      32'(done_pulse),     32'd1);
        chk({tag, "_done_vld"},  32'(lane_valid),     32'd0);
        chk({tag, "_done_sel"},  32'(lane_sel),       32'd0);
        chk({tag, "_seq"},       32'(status_reg[31:16]), 32'(exp_seq));
        chk({tag, "_lanes"},     32'(status_reg[15:8]),  32'd8);
        chk({tag, "_done_busy"}, 32'(status_reg[0]),  32'd1);
        tick();
        chk({tag, "_done_1cyc"}, 32'(done_pulse),     32'd0);
        chk({tag, "_idle"},      32'(status_reg[0]),  32'd0);
        ctrl_reg   = 32'h0;
        lane_ready = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        user_rst_n = 1'b0;
        seed_data  = 32'h0;
        ctrl_reg   = 32'h0;
        sync_in    = 1'b0;
        lane_ready = 1'b1;
        exp_seq    = 16'h0;
        #12;
        chk("rst_valid",  32'(lane_valid), 32'd0);
        chk("rst_status", status_reg,      32'h0);
        chk("rst_seed",   lane_seed,       32'h0);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        tick();

        // Immediate mode, ready high; a coincident level stays high afterwards.
        seed_data = 32'h0000_0010;
        ctrl_reg  = 32'h3;
        tick();
        chk("imm_seed1_lit", exp_seed(32'h10, 1), 32'h9E3779C9);
        run_lanes("imm", 32'h0000_0010, 1'b0, 32'h0, 1'b0);

        // Sync mode: a sync coincident with arm is ignored, backpressure 1010.
        seed_data = 32'h1234_5678;
        ctrl_reg  = 32'h1;
        sync_in   = 1'b1;
        tick();
        sync_in = 1'b0;
        chk("arm_armed", 32'(status_reg[1]),    32'd1);
        chk("arm_busy",  32'(status_reg[0]),    32'd1);
        chk("arm_lanes", 32'(status_reg[15:8]), 32'd0);
        chk("arm_valid", 32'(lane_valid),       32'd0);
        repeat (19) tick();
        chk("arm_wait_valid", 32'(lane_valid),  32'd0);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        chk("sync_armed_clr", 32'(status_reg[1]), 32'd0);
        run_lanes("sync_bp", 32'h1234_5678, 1'b1, 32'h0, 1'b0);

        // Lane 2 accumulator wraps to zero and must be substituted.
        seed_data = 32'hC391_0C8E;
        ctrl_reg  = 32'h3;
        tick();
        run_lanes("zero", 32'hC391_0C8E, 1'b0, 32'h0, 1'b0);

        // Re-arm during LOAD flags overrun without disturbing the sequence.
        seed_data = 32'hCAFE_0001;
        ctrl_reg  = 32'h3;
        tick();
        run_lanes("ovr", 32'hCAFE_0001, 1'b0, 32'h3, 1'b0);
        chk("ovr_set", 32'(status_reg[2]), 32'd1);
        ctrl_reg = 32'h4;
        tick();
        chk("ovr_clr", 32'(status_reg[2]), 32'd0);
        ctrl_reg = 32'h0;
        tick();
        seed_data = 32'h0BAD_F00D;
        ctrl_reg  = 32'h3;
        tick();
        run_lanes("ovr_both", 32'h0BAD_F00D, 1'b0, 32'h7, 1'b0);
        chk("ovr_set_wins", 32'(status_reg[2]), 32'd1);
        ctrl_reg = 32'h4;
        tick();
        ctrl_reg = 32'h0;
        tick();

        // seed_data changes mid-LOAD must not affect the snapshot.
        seed_data = 32'h8000_0000;
        ctrl_reg  = 32'h3;
        tick();
        run_lanes("snap", 32'h8000_0000, 1'b1, 32'h0, 1'b1);

        // Asynchronous reset in the middle of a load.
        seed_data = 32'h0000_0055;
        ctrl_reg  = 32'h3;
        tick();
        tick();
        tick();
        chk("midrst_pre_valid", 32'(lane_valid), 32'd1);
        user_rst_n = 1'b0;
        #1;
        chk("midrst_valid",  32'(lane_valid), 32'd0);
        chk("midrst_sel",    32'(lane_sel),   32'd0);
        chk("midrst_seed",   lane_seed,       32'h0);
        chk("midrst_done",   32'(done_pulse), 32'd0);
        chk("midrst_status", status_reg,      32'h0);
        ctrl_reg = 32'h0;
        @(negedge user_clk);
        user_rst_n = 1'b1;
        tick();
        chk("postrst_status", status_reg,      32'h0);
        chk("postrst_valid",  32'(lane_valid), 32'd0);
        exp_seq = 16'h0;

        // seq_count wrap from 16'hFFFF.
        force dut.r_seq_count = 16'hFFFF;
        tick();
        release dut.r_seq_count;
        tick();
        chk("wrap_pre", 32'(status_reg[31:16]), 32'h0000_FFFF);
        exp_seq   = 16'hFFFF;
        seed_data = 32'hA5A5_0000;
        ctrl_reg  = 32'h3;
        tick();
        run_lanes("wrap", 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);
        chk("wrap_zero", 32'(status_reg[31:16]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
